bullet_pool_ctrl: RTL and testbench
===================================

# bullet_pool_ctrl

Frame-rate scheduler that shares a fixed pool of bullet instances between player fire requests. It decodes the space key from the keyboard keycode bus, enforces a fire cooldown, and picks a free bullet slot round-robin. It issues a one-frame launch pulse with the ship muzzle position and tracks which slots are in flight until each bullet reports hit or out-of-bounds. It sits between the keyboard/ship logic and the array of bullet instances, and feeds `slot_busy` to the colour mapper and collision logic.

## Interface
- `N_BULLETS`, 4: pool size, 2..8.
- `COOLDOWN`, 6: frames after a launch during which no new launch is issued, 1..15.
- `MUZZLE_DY`, 4: pixels subtracted from `ship_Y` for the launch Y.
- `frame_clk` in 1: frame clock, the only clock.
- `Reset` in 1: asynchronous, active-high; clears all state.
- `game_over` in 1: freezes launching; clears the pool.
- `start_screen` in 1: same effect as `game_over`.
- `space_key` in 25: three packed keycodes in [23:16], [15:8] and [7:0]; bit 24 is ignored.
- `ship_X`, `ship_Y` in 10 each: ship position, sampled at launch.
- `slot_done` in N_BULLETS: per-slot level, high while that bullet has hit or is off-screen.
- `fire` out N_BULLETS: one-hot launch pulse, exactly one frame long.
- `fire_X`, `fire_Y` out 10 each: launch position, valid while `fire` ≠ 0.
- `slot_busy` out N_BULLETS: slot is in flight.
- `busy_count` out $clog2(N_BULLETS+1): population count of `slot_busy`.
- `ready` out 1: FSM is in READY.

## Operation
- `space_pressed` = any byte of `space_key[23:0]` equals SPACE_KEYCODE (8'h2c).
- `press_edge` = `space_pressed` & ~`space_prev`. `space_prev` is registered every frame.
- FSM states: OFF, READY, COOL.
  - OFF: entered on reset, or whenever `game_over`|`start_screen` is high, from any state.
    - In OFF, `slot_busy`, `fire` and the cooldown counter are all cleared.
    - Leaves to READY on the first frame with both inputs low.
  - READY: on a fire trigger with at least one free slot, launch and go to COOL.
    - If no slot is free, the trigger is dropped. The FSM stays in READY and does not queue the request.
  - COOL: the counter loads `COOLDOWN-1` on entry and decrements each frame. At 0 the FSM returns to READY.
    - Triggers during COOL are dropped.
- Fire trigger = `press_edge`. See Configuration for the autofire variant.
- Launch actions:
  - `fire[k]`=1 for the chosen slot k.
  - `fire_X`=`ship_X`.
  - `fire_Y` = `ship_Y` − `MUZZLE_DY`, saturating at 0.
  - `slot_busy[k]`=1.
  - The round-robin pointer moves to k+1 mod N.
- Slot choice: the first free slot at or after the pointer, wrapping around. Free = ~`slot_busy` as registered at the start of the frame.
- Release: `slot_done[i]` high clears `slot_busy[i]` on that edge. A slot being launched this frame ignores `slot_done` for that frame.
- Simultaneous release and launch request: a slot freed on edge t is launchable from edge t+1 only. This avoids a combinational path from `slot_done` to `fire`.
- Launching with `ship_Y` < MUZZLE_DY is still allowed. The Y saturates and the bullet instance retires the bullet next frame.

## Timing
- Reset values:
  - state=OFF, `fire`=0, `fire_X`=0, `fire_Y`=0, `slot_busy`=0, `busy_count`=0, `ready`=0.
  - Pointer=0, counter=0, `space_prev`=0.
- All outputs are registered.
- Launch latency: a key edge sampled at edge t produces `fire` high after edge t, for one frame.
- The minimum spacing between launches is COOLDOWN+1 frames.
- `busy_count` and `slot_busy` update on the same edge.
- `Reset` asserted mid-flight aborts any pulse immediately, asynchronously.

## Configuration
- `BULLET_AUTOFIRE_EN` defined: the fire trigger is `space_pressed` (level). Holding space launches once every COOLDOWN+1 frames while slots are free.
- Not defined: edge-triggered only. Holding space yields exactly one launch.

## Structure
- `bullet_pkg` holds:
  - SPACE_KEYCODE (8'h2c).
  - The default N_BULLETS.
  - The `fire_state_t` enum {OFF, READY, COOL}.
  - The screen-limit constants shared with the bullet instances.
- One sub-module, `rr_slot_picker`: combinational. Takes free mask + pointer and returns a one-hot grant and a found flag. It is instantiated once.

## Test plan
- Reset, then `start_screen`=0 with space held from frame 0. Required: one frame in OFF, then READY. Exactly one `fire`=4'b0001 with `fire_X`/`fire_Y` = ship position − (0,4). No second launch while space is held (edge mode).
- Four presses, each 8 frames apart, with `slot_done`=0. Required: `fire` = 0001, 0010, 0100, 1000; `busy_count`=4. A fifth press produces no pulse and the FSM stays READY.
- Press at frame t, press again at t+3 with COOLDOWN=6. Required: the second press is ignored; a press at t+7 launches.
- `slot_done[1]` pulsed on the same edge as a launch request while slots 0..3 are busy. Required: no launch that frame. A press next frame (after cooldown) launches slot 1.
- `game_over` asserted with 3 slots busy and the counter at 3. Required: next edge `slot_busy`=0, `ready`=0, no `fire`. Deassert, and READY follows one frame later.
- `BULLET_AUTOFIRE_EN` build with space held for 20 frames and COOLDOWN=6. Required: launches at frames 1, 8 and 15.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared constants and types for the bullet pool scheduler and the bullet instances.
package bullet_pkg;

    // Keyboard scan code of the space bar
    localparam logic [7:0] SPACE_KEYCODE = 8'h2c;

    // Default pool size
    localparam int unsigned N_BULLETS_DEFAULT = 4;

    // Screen limits shared with the bullet instances
    localparam logic [9:0] SCREEN_X_MIN = 10'd0;
    localparam logic [9:0] SCREEN_X_MAX = 10'd639;
    localparam logic [9:0] SCREEN_Y_MIN = 10'd0;
    localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

    // Fire scheduler states
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        READY = 2'd1,
        COOL  = 2'd2
    } fire_state_t;

endpackage

// File: rtl/rr_slot_picker.sv
// Round-robin free-slot picker: grants the first free slot at or after the pointer, wrapping.
module rr_slot_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  i_free,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_found
);

    // Walk offsets from farthest to nearest so the nearest free slot is the last one written
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            for (int i = 0; i < int'(N); i++) begin
                if ((i == ((int'(i_ptr) + off) % int'(N))) && i_free[i]) begin
                    o_grant    = '0;
                    o_grant[i] = 1'b1;
                    o_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Frame-rate bullet pool scheduler: space-key decode, fire cooldown, round-robin slot launch
// and in-flight tracking. Optional macro BULLET_AUTOFIRE_EN makes a held space key re-fire
// every COOLDOWN+1 frames instead of once per press.
module bullet_pool_ctrl
    import bullet_pkg::*;
#(
    parameter int unsigned N_BULLETS = N_BULLETS_DEFAULT,
    parameter int unsigned COOLDOWN  = 6,
    parameter int unsigned MUZZLE_DY = 4
) (
    input  logic                           i_frame_clk,
    input  logic                           i_reset,
    input  logic                           i_game_over,
    input  logic                           i_start_screen,
    input  logic [24:0]                    i_space_key,
    input  logic [9:0]                     i_ship_x,
    input  logic [9:0]                     i_ship_y,
    input  logic [N_BULLETS-1:0]           i_slot_done,
    output logic [N_BULLETS-1:0]           o_fire,
    output logic [9:0]                     o_fire_x,
    output logic [9:0]                     o_fire_y,
    output logic [N_BULLETS-1:0]           o_slot_busy,
    output logic [$clog2(N_BULLETS+1)-1:0] o_busy_count,
    output logic                           o_ready
);

    localparam int unsigned PW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
    localparam int unsigned CW = $clog2(N_BULLETS + 1);
    localparam logic [9:0]  DY = 10'(MUZZLE_DY);

    fire_state_t     r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic            r_space_prev;
    logic [N_BULLETS-1:0] r_fire;
    logic [9:0]      r_fire_x, r_fire_y;
    logic [N_BULLETS-1:0] r_slot_busy, w_busy_nxt;
    logic [CW-1:0]   r_busy_count, w_count_nxt;

    logic            w_off;
    logic            w_space_pressed;
    logic            w_trigger;
    logic            w_launch;
    logic [N_BULLETS-1:0] w_grant;
    logic            w_found;
    logic [PW-1:0]   w_grant_idx;
    logic [9:0]      w_launch_y;
    logic            w_unused_key_msb;

    assign w_unused_key_msb = i_space_key[24];

    assign w_off = i_game_over | i_start_screen;

    assign w_space_pressed = (i_space_key[7:0]   == SPACE_KEYCODE) |
                             (i_space_key[15:8]  == SPACE_KEYCODE) |
                             (i_space_key[23:16] == SPACE_KEYCODE);

`ifdef BULLET_AUTOFIRE_EN
    assign w_trigger = w_space_pressed;
`else
    assign w_trigger = w_space_pressed & ~r_space_prev;
`endif

    // Free mask is the registered busy state, so a slot released this edge waits one frame
    rr_slot_picker #(
        .N  (N_BULLETS),
        .PW (PW)
    ) u_picker (
        .i_free  (~r_slot_busy),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    assign w_launch = (r_state == READY) & ~w_off & w_trigger & w_found;

    assign w_launch_y = (i_ship_y >= DY) ? (i_ship_y - DY) : 10'd0;

    // Grant index, pointer advance, busy mask and population count
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < int'(N_BULLETS); i++) begin
            if (w_grant[i]) begin
                w_grant_idx = PW'(i);
            end
        end
        w_ptr_nxt = r_ptr;
        if (w_launch) begin
            w_ptr_nxt = (w_grant_idx == PW'(N_BULLETS - 1)) ? '0 : w_grant_idx + 1'b1;
        end
        if (w_off) begin
            w_busy_nxt = '0;
        end else begin
            w_busy_nxt = (r_slot_busy & ~i_slot_done) | (w_launch ? w_grant : '0);
        end
        w_count_nxt = '0;
        for (int i = 0; i < int'(N_BULLETS); i++) begin
            w_count_nxt = w_count_nxt + CW'(w_busy_nxt[i]);
        end
    end

    // FSM next state and cooldown counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_off) begin
            w_state_nxt = OFF;
            w_cnt_nxt   = 4'd0;
        end else begin
            unique case (r_state)
                OFF:   w_state_nxt = READY;
                READY: begin
                    if (w_launch) begin
                        w_state_nxt = COOL;
                        w_cnt_nxt   = 4'(COOLDOWN - 1);
                    end
                end
                COOL: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = READY;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = OFF;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // State registers; a key already held when play starts counts as a fresh press
    always_ff @(posedge i_frame_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= OFF;
            r_cnt        <= 4'd0;
            r_ptr        <= '0;
            r_space_prev <= 1'b0;
            r_fire       <= '0;
            r_fire_x     <= 10'd0;
            r_fire_y     <= 10'd0;
            r_slot_busy  <= '0;
            r_busy_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_space_prev <= (w_off || r_state == OFF) ? 1'b0 : w_space_pressed;
            r_fire       <= w_launch ? w_grant : '0;
            r_slot_busy  <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
            if (w_launch) begin
                r_fire_x <= i_ship_x;
                r_fire_y <= w_launch_y;
            end
        end
    end

    assign o_fire       = r_fire;
    assign o_fire_x     = r_fire_x;
    assign o_fire_y     = r_fire_y;
    assign o_slot_busy  = r_slot_busy;
    assign o_busy_count = r_busy_count;
    assign o_ready      = (r_state == READY);

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed bench for bullet_pool_ctrl with default parameters (N=4, COOLDOWN=6, MUZZLE_DY=4).
module tb_bullet_pool_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_over;
    logic        start_screen;
    logic [24:0] space_key;
    logic [9:0]  ship_x, ship_y;
    logic [3:0]  slot_done;
    logic [3:0]  fire;
    logic [9:0]  fire_x, fire_y;
    logic [3:0]  slot_busy;
    logic [2:0]  busy_count;
    logic        ready;

    int errors = 0;
    int checks = 0;

    localparam logic [24:0] KEY_NONE = 25'h0000000;
    localparam logic [24:0] KEY_B0   = 25'h000002c;
    localparam logic [24:0] KEY_B1   = 25'h0002c00;
    localparam logic [24:0] KEY_B2   = 25'h02c0000;
    localparam logic [24:0] KEY_MSB  = 25'h11a1b1c;

    always #5 clk = ~clk;

    bullet_pool_ctrl dut (
        .i_frame_clk    (clk),
        .i_reset        (rst),
        .i_game_over    (game_over),
        .i_start_screen (start_screen),
        .i_space_key    (space_key),
        .i_ship_x       (ship_x),
        .i_ship_y       (ship_y),
        .i_slot_done    (slot_done),
        .o_fire         (fire),
        .o_fire_x       (fire_x),
        .o_fire_y       (fire_y),
        .o_slot_busy    (slot_busy),
        .o_busy_count   (busy_count),
        .o_ready        (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        game_over    = 1'b0;
        start_screen = 1'b1;
        space_key    = KEY_NONE;
        ship_x       = 10'd100;
        ship_y       = 10'd200;
        slot_done    = 4'b0000;
        tick();
        tick();
        chk("rst_fire", fire, 4'b0000);
        chk("rst_fire_x", fire_x, 10'd0);
        chk("rst_fire_y", fire_y, 10'd0);
        chk("rst_busy", slot_busy, 4'b0000);
        chk("rst_count", busy_count, 3'd0);
        chk("rst_ready", ready, 1'b0);
        rst = 1'b0;
        tick();
        chk("start_screen_holds_off", ready, 1'b0);

        // Leave the start screen with space already held
        start_screen = 1'b0;
        space_key    = KEY_B0;
        tick();
        chk("off_to_ready", ready, 1'b1);
        chk("off_no_fire", fire, 4'b0000);

`ifdef BULLET_AUTOFIRE_EN
        // Held space: launches at frames 1, 8 and 15 of the hold
        chk("af_f0_fire", fire, 4'b0000);
        for (int f = 1; f < 20; f++) begin
            tick();
            if (f == 1)       chk("af_f1_fire", fire, 4'b0001);
            else if (f == 8)  chk("af_f8_fire", fire, 4'b0010);
            else if (f == 15) chk("af_f15_fire", fire, 4'b0100);
            else              chk("af_idle_fire", fire, 4'b0000);
        end
        chk("af_busy", slot_busy, 4'b0111);
        chk("af_count", busy_count, 3'd3);
`else
        tick();
        chk("p1_fire", fire, 4'b0001);
        chk("p1_fire_x", fire_x, 10'd100);
        chk("p1_fire_y", fire_y, 10'd196);
        chk("p1_busy", slot_busy, 4'b0001);
        chk("p1_count", busy_count, 3'd1);
        chk("p1_ready", ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_no_refire", fire, 4'b0000);
        end
        space_key = KEY_NONE;
        tick();

        // Presses 2..4, eight frames apart
        ship_x = 10'd300; ship_y = 10'd50; space_key = KEY_B1;
        tick();
        chk("p2_fire", fire, 4'b0010);
        chk("p2_fire_x", fire_x, 10'd300);
        chk("p2_fire_y", fire_y, 10'd46);
        space_key = KEY_NONE;
        for (int i = 0; i < 7; i++) tick();
        ship_x = 10'd639; ship_y = 10'd4; space_key = KEY_B2;
        tick();
        chk("p3_fire", fire, 4'b0100);
        chk("p3_fire_y_zero", fire_y, 10'd0);
        space_key = KEY_NONE;
        for (int i = 0; i < 7; i++) tick();
        ship_x = 10'd7; ship_y = 10'd2; space_key = KEY_B0;
        tick();
        chk("p4_fire", fire, 4'b1000);
        chk("p4_fire_x", fire_x, 10'd7);
        chk("p4_fire_y_sat", fire_y, 10'd0);
        chk("p4_busy", slot_busy, 4'b1111);
        chk("p4_count", busy_count, 3'd4);
        space_key = KEY_NONE;
        for (int i = 0; i < 7; i++) tick();
        space_key = KEY_B0;
        tick();
        chk("p5_full_no_fire", fire, 4'b0000);
        chk("p5_stays_ready", ready, 1'b1);

        // Release and launch request on the same edge
        space_key = KEY_NONE;
        tick();
        space_key = KEY_B1; slot_done = 4'b0010;
        tick();
        chk("rel_same_edge_no_fire", fire, 4'b0000);
        chk("rel_busy", slot_busy, 4'b1101);
        chk("rel_count", busy_count, 3'd3);
        chk("rel_ready", ready, 1'b1);
        space_key = KEY_NONE; slot_done = 4'b0000;
        tick();
        ship_x = 10'd200; ship_y = 10'd300; space_key = KEY_B0;
        tick();
        chk("rel_next_fire", fire, 4'b0010);
        chk("rel_next_fire_y", fire_y, 10'd296);
        chk("rel_next_busy", slot_busy, 4'b1111);

        // Free everything, then exercise the cooldown window
        space_key = KEY_NONE; slot_done = 4'b1111;
        tick();
        chk("all_done_busy", slot_busy, 4'b0000);
        chk("all_done_count", busy_count, 3'd0);
        slot_done = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        space_key = KEY_B0;
        tick();
        chk("cd_t_fire", fire, 4'b0100);
        space_key = KEY_NONE;
        tick();
        tick();
        space_key = KEY_B0;
        tick();
        chk("cd_t3_ignored", fire, 4'b0000);
        space_key = KEY_NONE;
        tick();
        tick();
        chk("cd_t5_not_ready", ready, 1'b0);
        tick();
        chk("cd_t6_ready", ready, 1'b1);
        space_key = KEY_B0;
        tick();
        chk("cd_t7_fire", fire, 4'b1000);
        chk("cd_busy", slot_busy, 4'b1100);

        // game_over with three slots busy and counter mid-cooldown
        space_key = KEY_NONE;
        for (int i = 0; i < 6; i++) tick();
        space_key = KEY_B0;
        tick();
        chk("go_pre_fire", fire, 4'b0001);
        chk("go_pre_count", busy_count, 3'd3);
        space_key = KEY_NONE;
        tick();
        tick();
        game_over = 1'b1;
        tick();
        chk("go_busy", slot_busy, 4'b0000);
        chk("go_count", busy_count, 3'd0);
        chk("go_ready", ready, 1'b0);
        chk("go_fire", fire, 4'b0000);
        space_key = KEY_B0;
        tick();
        chk("go_press_ignored", fire, 4'b0000);
        space_key = KEY_NONE; game_over = 1'b0;
        tick();
        chk("go_release_ready", ready, 1'b1);
        chk("go_release_fire", fire, 4'b0000);

        // Bit 24 and foreign keycodes do not count as space
        space_key = KEY_MSB;
        tick();
        chk("msb_no_fire", fire, 4'b0000);
        space_key = KEY_NONE;
        tick();
        ship_x = 10'd10; ship_y = 10'd10; space_key = KEY_B2;
        tick();
        chk("b2_fire", fire, 4'b0010);
        chk("b2_fire_y", fire_y, 10'd6);

        // Asynchronous reset aborts the pulse without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_fire", fire, 4'b0000);
        chk("async_rst_busy", slot_busy, 4'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
